// File: rtl/wt931_pkg.sv
// Shared constants, FSM encoding and helpers for the WT931 IMU receive path.
package wt931_pkg;

  localparam logic [7:0]  WT931_HDR       = 8'h55;
  localparam logic [7:0]  WT931_T_ACC     = 8'h51;
  localparam logic [7:0]  WT931_T_GYRO    = 8'h52;
  localparam logic [7:0]  WT931_T_ANGLE   = 8'h53;
  localparam int unsigned WT931_FRAME_LEN = 11;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_TYPE    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } frame_state_e;

  // Little-endian 16-bit word from two payload bytes.
  function automatic logic [15:0] le_word(input logic [7:0] lo, input logic [7:0] hi);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample strobe generator: one-cycle pulse every CLK_FREQ/(BAUD*OVERSAMPLE) cycles.
module uart_tick_gen #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic tick
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Wrap the divider at DIV-1.
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (cnt == CNT_W'(DIV - 1)) begin
      cnt_nxt = '0;
    end
  end

  // Tick is registered so it is high exactly while the count sits at DIV-1.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == CNT_W'(DIV - 1));
    end
  end

endmodule

// File: rtl/wt931_frame_ctrl.sv
// WT931 receive sequencer: pops bytes from the UART receiver, assembles and
// checksums 11-byte frames, and publishes acc/gyro/angle/temp vectors.
module wt931_frame_ctrl
  import wt931_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned BAUD          = 9600,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned TIMEOUT_TICKS = 480
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  output logic        uart_rx_clk,
  output logic        rx_en,
  input  logic        rx_ready,
  input  logic        rx_busy,
  input  logic [7:0]  rx_data,
  output logic [47:0] acc,
  output logic [47:0] gyro,
  output logic [47:0] angle,
  output logic [15:0] temp,
  output logic        acc_upd,
  output logic        gyro_upd,
  output logic        angle_upd,
  output logic        frame_err
);

  localparam int unsigned TMO_W    = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [3:0]  LAST_IDX = 4'(WT931_FRAME_LEN - 2);

  frame_state_e     state;
  logic [3:0]       idx;
  logic [7:0]       sum;
  logic [7:0]       frame_type;
  logic [7:0]       byte_q;
  logic [7:0]       pbuf [8];
  logic [TMO_W-1:0] tmo;
  logic [15:0]      w_x, w_y, w_z, w_t;
  logic             unused_rx_busy;

  assign unused_rx_busy = rx_busy;

  uart_tick_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tick      (uart_rx_clk)
  );

  // Pop one byte per handshake; rx_en never stays high two cycles in a row.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rx_en  <= 1'b0;
      byte_q <= '0;
    end else begin
      rx_en <= rx_ready && !rx_en;
      if (rx_ready && !rx_en) begin
        byte_q <= rx_data;
      end
    end
  end

  // Payload words in {hi,lo} order: x, y, z, temperature.
  always_comb begin
    w_x = le_word(pbuf[0], pbuf[1]);
    w_y = le_word(pbuf[2], pbuf[3]);
    w_z = le_word(pbuf[4], pbuf[5]);
    w_t = le_word(pbuf[6], pbuf[7]);
  end

  // Frame FSM: advances on each popped byte (rx_en marks byte_q valid); timeout in-frame.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= ST_HUNT;
      idx        <= '0;
      sum        <= '0;
      frame_type <= '0;
      tmo        <= '0;
      for (int i = 0; i < 8; i++) begin
        pbuf[i] <= '0;
      end
      acc        <= '0;
      gyro       <= '0;
      angle      <= '0;
      temp       <= '0;
      acc_upd    <= 1'b0;
      gyro_upd   <= 1'b0;
      angle_upd  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      acc_upd   <= 1'b0;
      gyro_upd  <= 1'b0;
      angle_upd <= 1'b0;
      frame_err <= 1'b0;
      if (rx_en) begin
        tmo <= '0;
        case (state)
          ST_HUNT: begin
            if (byte_q == WT931_HDR) begin
              state <= ST_TYPE;
              sum   <= WT931_HDR;
              idx   <= 4'd1;
            end
          end
          ST_TYPE: begin
            frame_type <= byte_q;
            sum        <= sum + byte_q;
            idx        <= 4'd2;
            state      <= ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            pbuf[3'(idx - 4'd2)] <= byte_q;
            sum                  <= sum + byte_q;
            if (idx == LAST_IDX) begin
              state <= ST_CHECK;
            end else begin
              idx <= idx + 4'd1;
            end
          end
          ST_CHECK: begin
            state <= ST_HUNT;
            idx   <= '0;
            if (byte_q == sum) begin
              case (frame_type)
                WT931_T_ACC: begin
                  acc     <= {w_z, w_y, w_x};
                  temp    <= w_t;
                  acc_upd <= 1'b1;
                end
                WT931_T_GYRO: begin
                  gyro     <= {w_z, w_y, w_x};
                  temp     <= w_t;
                  gyro_upd <= 1'b1;
                end
                WT931_T_ANGLE: begin
                  angle     <= {w_z, w_y, w_x};
                  temp      <= w_t;
                  angle_upd <= 1'b1;
                end
                default: ;
              endcase
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end else if (state != ST_HUNT && uart_rx_clk) begin
        if (tmo == TMO_W'(TIMEOUT_TICKS - 1)) begin
          state     <= ST_HUNT;
          idx       <= '0;
          tmo       <= '0;
          frame_err <= 1'b1;
        end else begin
          tmo <= tmo + TMO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wt931_frame_ctrl.sv
// Self-checking bench for wt931_frame_ctrl: frame-level model checked every cycle
// plus literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_wt931_frame_ctrl;

  localparam int unsigned TB_TMO = 24;
  localparam int          DIV_M  = 50_000_000 / (9600 * 16);

  typedef logic [7:0] bq_t[$];

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        rx_ready  = 1'b0;
  logic        rx_busy   = 1'b0;
  logic [7:0]  rx_data   = 8'h00;
  logic        uart_rx_clk, rx_en;
  logic [47:0] acc, gyro, angle;
  logic [15:0] temp;
  logic        acc_upd, gyro_upd, angle_upd, frame_err;

  wt931_frame_ctrl #(
    .CLK_FREQ      (50_000_000),
    .BAUD          (9600),
    .OVERSAMPLE    (16),
    .TIMEOUT_TICKS (TB_TMO)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .uart_rx_clk (uart_rx_clk),
    .rx_en       (rx_en),
    .rx_ready    (rx_ready),
    .rx_busy     (rx_busy),
    .rx_data     (rx_data),
    .acc         (acc),
    .gyro        (gyro),
    .angle       (angle),
    .temp        (temp),
    .acc_upd     (acc_upd),
    .gyro_upd    (gyro_upd),
    .angle_upd   (angle_upd),
    .frame_err   (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int r0     = 0;
  bit chk_en = 1'b0;

  // Frame-level reference state
  logic [47:0] m_acc, m_gyro, m_angle;
  logic [15:0] m_temp;
  bit          e_acc, e_gyro, e_angle, e_err;
  logic [7:0]  fq[$];
  int          tcnt;
  bit          p_ready, p_en;
  logic [7:0]  p_data, cap_byte;

  // Observed pulse counters for the literal scenario checks
  int n_acc = 0, n_gyro = 0, n_angle = 0, n_err = 0;

  always @(posedge sys_clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit tick_exp(input int c);
    return (c >= r0) && (((c - r0) % DIV_M) == DIV_M - 1);
  endfunction

  task automatic model_reset();
    m_acc = '0; m_gyro = '0; m_angle = '0; m_temp = '0;
    fq.delete();
    tcnt = 0;
    p_ready = 1'b0; p_en = 1'b0; p_data = '0; cap_byte = '0;
  endtask

  // Consume one byte at frame granularity: collect 11 bytes starting at 0x55, then judge.
  task automatic model_byte(input logic [7:0] b);
    int s;
    logic [15:0] w0, w1, w2, w3;
    tcnt = 0;
    if (fq.size() == 0) begin
      if (b == 8'h55) fq.push_back(b);
    end else begin
      fq.push_back(b);
      if (fq.size() == 11) begin
        s = 0;
        for (int i = 0; i < 10; i++) s += int'(fq[i]);
        if (8'(s) == b) begin
          w0 = {fq[3], fq[2]};
          w1 = {fq[5], fq[4]};
          w2 = {fq[7], fq[6]};
          w3 = {fq[9], fq[8]};
          case (fq[1])
            8'h51: begin m_acc   = {w2, w1, w0}; m_temp = w3; e_acc   = 1'b1; end
            8'h52: begin m_gyro  = {w2, w1, w0}; m_temp = w3; e_gyro  = 1'b1; end
            8'h53: begin m_angle = {w2, w1, w0}; m_temp = w3; e_angle = 1'b1; end
            default: ;
          endcase
        end else begin
          e_err = 1'b1;
        end
        fq.delete();
      end
    end
  endtask

  // Per-cycle comparison against the reference
  always @(negedge sys_clk) begin : chk
    bit en_now;
    if (chk_en) begin
      e_acc = 1'b0; e_gyro = 1'b0; e_angle = 1'b0; e_err = 1'b0;
      if (p_en) begin
        model_byte(cap_byte);
      end else if (fq.size() != 0 && tick_exp(cyc - 1)) begin
        tcnt++;
        if (tcnt == int'(TB_TMO)) begin
          e_err = 1'b1;
          fq.delete();
          tcnt = 0;
        end
      end
      en_now = p_ready && !p_en;
      if (en_now) cap_byte = p_data;
      check("uart_rx_clk", 64'(uart_rx_clk), 64'(tick_exp(cyc)));
      check("rx_en",       64'(rx_en),       64'(en_now));
      check("acc",         64'(acc),         64'(m_acc));
      check("gyro",        64'(gyro),        64'(m_gyro));
      check("angle",       64'(angle),       64'(m_angle));
      check("temp",        64'(temp),        64'(m_temp));
      check("acc_upd",     64'(acc_upd),     64'(e_acc));
      check("gyro_upd",    64'(gyro_upd),    64'(e_gyro));
      check("angle_upd",   64'(angle_upd),   64'(e_angle));
      check("frame_err",   64'(frame_err),   64'(e_err));
      p_en    = en_now;
      p_ready = rx_ready;
      p_data  = rx_data;
      n_acc   += int'(acc_upd);
      n_gyro  += int'(gyro_upd);
      n_angle += int'(angle_upd);
      n_err   += int'(frame_err);
    end
  end

  task automatic do_reset();
    chk_en = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b0;
    rx_ready  = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    model_reset();
    r0     = cyc;
    chk_en = 1'b1;
  endtask

  task automatic send_seq(input bq_t s);
    foreach (s[i]) begin
      @(posedge sys_clk); #1;
      rx_ready = 1'b1;
      rx_data  = s[i];
      @(posedge sys_clk); #1;
      rx_ready = 1'b0;
      repeat (2) @(posedge sys_clk);
    end
    repeat (4) @(posedge sys_clk);
  endtask

  initial begin : stim
    int first, second, pops, consec, a0, g0, n0, e0;
    bit prev;
    bq_t s;

    do_reset();
    check("reset_acc",  64'(acc),  64'h0);
    check("reset_temp", 64'(temp), 64'h0);

    // Oversample strobe position and period
    first = -1; second = -1;
    for (int i = 0; i < 700; i++) begin
      @(negedge sys_clk);
      if (uart_rx_clk) begin
        if (first < 0) first = cyc - r0;
        else if (second < 0) second = cyc - r0;
      end
    end
    check("tick_first",  64'(first),          64'd324);
    check("tick_period", 64'(second - first), 64'd325);

    // rx_ready held high: pops alternate, never back to back
    @(posedge sys_clk); #1;
    rx_ready = 1'b1; rx_data = 8'h00;
    pops = 0; consec = 0; prev = 1'b0;
    repeat (6) begin
      @(negedge sys_clk);
      if (rx_en) pops++;
      if (rx_en && prev) consec++;
      prev = rx_en;
    end
    @(posedge sys_clk); #1;
    rx_ready = 1'b0;
    repeat (4) @(posedge sys_clk);
    check("hold_pops",   64'(pops),   64'd3);
    check("hold_consec", 64'(consec), 64'd0);

    // Good acceleration frame
    a0 = n_acc; g0 = n_gyro; n0 = n_angle;
    s = '{8'h55, 8'h51, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h40, 8'h00, 8'h46};
    send_seq(s);
    check("good_acc",       64'(acc),           64'h0030_0020_0010);
    check("good_temp",      64'(temp),          64'h0040);
    check("good_acc_upd_n", 64'(n_acc - a0),    64'd1);
    check("good_gyro_n",    64'(n_gyro - g0),   64'd0);
    check("good_angle_n",   64'(n_angle - n0),  64'd0);

    // Bad checksum
    a0 = n_acc; e0 = n_err;
    s = '{8'h55, 8'h51, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h40, 8'h00, 8'h47};
    send_seq(s);
    check("bad_err_n",  64'(n_err - e0), 64'd1);
    check("bad_acc",    64'(acc),        64'h0030_0020_0010);
    check("bad_upd_n",  64'(n_acc - a0), 64'd0);

    // Garbage before a valid angle frame
    n0 = n_angle;
    s = '{8'hAA, 8'h13, 8'h55, 8'h53, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'hB2};
    send_seq(s);
    check("resync_angle",   64'(angle),          64'h0003_0002_0001);
    check("resync_upd_n",   64'(n_angle - n0),   64'd1);
    check("resync_temp",    64'(temp),           64'h0004);

    // Inter-byte timeout, then a good gyro frame
    e0 = n_err; g0 = n_gyro;
    s = '{8'h55, 8'h52, 8'h00};
    send_seq(s);
    repeat ((int'(TB_TMO) + 2) * DIV_M) @(posedge sys_clk);
    check("tmo_err_n", 64'(n_err - e0), 64'd1);
    s = '{8'h55, 8'h52, 8'h05, 8'h00, 8'h06, 8'h00, 8'h07, 8'h00, 8'h08, 8'h00, 8'hC1};
    send_seq(s);
    check("tmo_gyro",   64'(gyro),          64'h0007_0006_0005);
    check("tmo_gyro_n", 64'(n_gyro - g0),   64'd1);

    // Unknown type with good checksum, 0x55 as payload data: dropped silently
    a0 = n_acc; g0 = n_gyro; n0 = n_angle; e0 = n_err;
    s = '{8'h55, 8'h54, 8'h55, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h53};
    send_seq(s);
    check("unk_pulses", 64'((n_acc - a0) + (n_gyro - g0) + (n_angle - n0) + (n_err - e0)), 64'd0);

    // Checksum wrapping past 255
    a0 = n_acc;
    s = '{8'h55, 8'h51, 8'hFF, 8'h7F, 8'h00, 8'h80, 8'h34, 8'h12, 8'h10, 8'h00, 8'hFA};
    send_seq(s);
    check("wrap_acc",   64'(acc),         64'h1234_8000_7FFF);
    check("wrap_temp",  64'(temp),        64'h0010);
    check("wrap_upd_n", 64'(n_acc - a0),  64'd1);

    // Reset in the middle of a frame
    s = '{8'h55, 8'h51, 8'h10, 8'h00, 8'h20};
    send_seq(s);
    do_reset();
    repeat (2) @(posedge sys_clk);
    a0 = n_acc; e0 = n_err;
    check("mid_rst_acc",   64'(acc),   64'h0);
    check("mid_rst_gyro",  64'(gyro),  64'h0);
    check("mid_rst_angle", 64'(angle), 64'h0);
    s = '{8'h55, 8'h51, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h40, 8'h00, 8'h46};
    send_seq(s);
    check("post_rst_acc",   64'(acc),          64'h0030_0020_0010);
    check("post_rst_upd_n", 64'(n_acc - a0),   64'd1);
    check("post_rst_err_n", 64'(n_err - e0),   64'd0);

    repeat (4) @(posedge sys_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
